dq4_serial_reader: RTL and testbench
====================================

DQ4_SERIAL_READER -- requirements
Module: dq4_serial_reader

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..16).
REQ-002 SHALL provide parameter MSB_FIRST, default 1; 1 = bit index 0 shifted out first, 0 = bit index WIDTH-1 first.
REQ-003 SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 D  input  [0:WIDTH-1]  parallel word to read out; bit 0 is leftmost.
REQ-007 en  input  1  load request; word D is accepted when en=1 and ready=1 at a rising edge.
REQ-008 ready  output  1  block idle and able to accept a word.
REQ-009 Q  output  1  serial data bit.
REQ-010 valid  output  1  Q carries a valid bit this cycle.
REQ-011 last  output  1  current Q is the final bit of the word.
REQ-012 stall  input  1  downstream hold; while 1, Q/valid/last and internal state hold.

Function
REQ-013 SHALL implement FSM with states IDLE and SHIFT, encoded as a 1-bit state register.
REQ-014 IDLE: ready=1, valid=0, last=0, Q=0.
REQ-015 IDLE and en=1 at an edge: capture D into shift register, load bit counter with WIDTH-1, go to SHIFT.
REQ-016 Latency: the first valid bit SHALL appear the cycle immediately after the accepting edge (1-cycle latency).
REQ-017 SHIFT: valid=1, ready=0, Q = current head bit of the shift register.
REQ-018 SHIFT with stall=0: shift register advances one bit per cycle, counter decrements by 1.
REQ-019 last SHALL be 1 exactly when valid=1 and counter=0.
REQ-020 SHIFT with counter=0 and stall=0: go to IDLE; ready=1 in the following cycle.
REQ-021 A word SHALL occupy exactly WIDTH non-stalled valid cycles; back-to-back words are separated by one IDLE cycle (throughput WIDTH+1 cycles/word).
REQ-022 en while ready=0 SHALL be ignored; no queueing, and the word in flight is not corrupted.
REQ-023 Changes on D outside an accepting edge SHALL NOT affect Q.
REQ-024 stall while in IDLE SHALL have no effect; en is still accepted.
REQ-025 Counter width SHALL be ceil(log2(WIDTH)) bits; no wrap-around is permitted (transition to IDLE occurs at 0).
REQ-026 Vacated shift-register positions SHALL be filled with 0.

Reset
REQ-027 With rst_n=0 at an edge: state=IDLE, shift register=0, counter=0.
REQ-028 Outputs after reset: ready=1, valid=0, last=0, Q=0.
REQ-029 Reset mid-word SHALL abort the word; no further bits of it are emitted.
REQ-030 rst_n=0 SHALL take priority over en and stall in the same cycle.

Structure
REQ-031 State encoding constants (IDLE, SHIFT) and the default WIDTH SHALL live in a shared package/include, dq_pkg, reused by the DQ4 writer side.
REQ-032 SHALL contain one sub-module, dq_shift_reg (WIDTH-bit load/shift/hold register with zero fill); FSM and counter stay in the top module.
REQ-033 All state SHALL be edge-triggered flip-flops; no latches, no combinational loops.

Verification
REQ-034 Reset: hold rst_n=0 for 2 cycles -> ready=1, valid=0, last=0, Q=0.
REQ-035 Single word: D=0110, en=1 for 1 cycle, MSB_FIRST=1 -> Q = 0,1,1,0 on 4 consecutive cycles, valid=1 on all four, last=1 on the 4th only, ready=1 on the 5th.
REQ-036 Back-to-back with en held high: D=1011 then D=0001 -> bits 1,0,1,1, one IDLE cycle, then 0,0,0,1; total 10 cycles.
REQ-037 Stall: D=1100, stall=1 during the 2nd bit for 3 cycles -> Q=1 held for 3 extra cycles; sequence 1,1,0,0 intact; last held with the 4th bit.
REQ-038 Ignored load: during SHIFT of 1010, en=1 with D=0101 -> output stays 1,0,1,0; the 0101 word is never emitted.
REQ-039 Mid-word reset: after 2 bits of 1111, rst_n=0 for 1 cycle -> next cycle valid=0, ready=1; no remaining bits emitted.

Source files
------------

// File: rtl/dq_pkg.sv
// Shared definitions for the DQ serial reader/writer pair.
// Holds the FSM state encoding, the default word width and a counter-width helper.
// No logic; imported by every DQ module.
package dq_pkg;

  // Default parallel word width for the DQ4 family.
  localparam int DQ_WIDTH = 4;

  // One-bit FSM state: waiting for a word, or streaming one out.
  typedef enum logic {
    DQ_IDLE  = 1'b0,
    DQ_SHIFT = 1'b1
  } dq_state_e;

  // Bits needed to count down from width-1 to 0.
  function automatic int dq_cnt_width(input int width);
    return (width < 3) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/dq_shift_reg.sv
// WIDTH-bit parallel-load shift register with zero fill.
// Latency: load/shift take effect at the next rising edge; head_o is registered.
// Backpressure: shift_i low holds contents (caller folds stall into shift_i).
module dq_shift_reg
  import dq_pkg::*;
#(
  parameter int WIDTH     = DQ_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [0:WIDTH-1] d_i,
  output logic             head_o
);

  logic [0:WIDTH-1] sr_q;
  logic [0:WIDTH-1] sr_d;

  // Next contents: load wins over shift; vacated positions take 0.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = d_i;
    end else if (shift_i) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[1:WIDTH-1], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[0:WIDTH-2]};
      end
    end
  end

  // Register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // The bit leaving the register next is the current head.
  assign head_o = MSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];

endmodule

// File: rtl/dq4_serial_reader.sv
// Parallel-to-serial reader: accepts a WIDTH-bit word, emits it one bit per cycle.
// Latency: first bit valid the cycle after the accepting edge; WIDTH+1 cycles per word.
// Backpressure: stall freezes Q/valid/last and all state while shifting; en ignored when busy.
module dq4_serial_reader
  import dq_pkg::*;
#(
  parameter int WIDTH     = DQ_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:WIDTH-1] D,
  input  logic             en,
  input  logic             stall,
  output logic             ready,
  output logic             Q,
  output logic             valid,
  output logic             last
);

  localparam int CNT_W = dq_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  dq_state_e        state_q;
  dq_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sr_load;
  logic             sr_shift;
  logic             sr_head;

  dq_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .d_i     (D),
    .head_o  (sr_head)
  );

  // Next state, bit counter and shift-register controls; outputs follow state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    ready    = 1'b0;
    valid    = 1'b0;
    last     = 1'b0;
    Q        = 1'b0;
    unique case (state_q)
      DQ_IDLE: begin
        // stall has no meaning here; only en matters.
        ready = 1'b1;
        if (en) begin
          sr_load = 1'b1;
          cnt_d   = CNT_MAX;
          state_d = DQ_SHIFT;
        end
      end
      DQ_SHIFT: begin
        valid = 1'b1;
        Q     = sr_head;
        last  = (cnt_q == '0);
        if (!stall) begin
          sr_shift = 1'b1;
          if (cnt_q == '0) begin
            // Leave at zero rather than wrapping; one idle cycle follows.
            state_d = DQ_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: begin
        state_d = DQ_IDLE;
      end
    endcase
  end

  // State and counter registers; reset overrides en and stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DQ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dq4_serial_reader.sv
// Bench for dq4_serial_reader: directed scenarios plus randomized traffic vs a queue model.
// Two instances: WIDTH=4 leftmost-first, and WIDTH=5 rightmost-first.
// Outputs sampled 1 time unit after each rising edge.
module tb_dq4_serial_reader;

  logic       clk;
  logic       rst_n;
  logic [0:3] D;
  logic       en;
  logic       stall;
  logic       ready;
  logic       Q;
  logic       valid;
  logic       last;

  logic [0:4] D2;
  logic       en2;
  logic       stall2;
  logic       ready2;
  logic       Q2;
  logic       valid2;
  logic       last2;

  int n_cmp;
  int n_bad;

  // Reference model: bits still to be emitted, in emission order.
  bit qa[$];
  bit qb[$];

  dq4_serial_reader #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (D),
    .en    (en),
    .stall (stall),
    .ready (ready),
    .Q     (Q),
    .valid (valid),
    .last  (last)
  );

  dq4_serial_reader #(.WIDTH(5), .MSB_FIRST(1'b0)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (D2),
    .en    (en2),
    .stall (stall2),
    .ready (ready2),
    .Q     (Q2),
    .valid (valid2),
    .last  (last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: advance the model with the inputs seen at the edge, then settle.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (qa.size() == 0) begin
        if (en) for (int i = 0; i < 4; i++) qa.push_back(D[i]);
      end else if (!stall) begin
        void'(qa.pop_front());
      end
      if (qb.size() == 0) begin
        if (en2) for (int i = 0; i < 5; i++) qb.push_back(D2[4-i]);
      end else if (!stall2) begin
        void'(qb.pop_front());
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; stall = 1'b1; D = 4'b1111;
    en2 = 1'b1; stall2 = 1'b0; D2 = 5'b11111;
    tick();
    tick();
    n_cmp++;
    if ({ready, valid, last, Q} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_a rvlq=%b expected 1000", {ready, valid, last, Q});
    end
    n_cmp++;
    if ({ready2, valid2, last2, Q2} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_b rvlq=%b expected 1000", {ready2, valid2, last2, Q2});
    end
    rst_n = 1'b1; en = 1'b0; stall = 1'b0; en2 = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [0:3] w;
    w = 4'b0110;
    D = w; en = 1'b1;
    tick();
    en = 1'b0; D = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({ready, valid, last, Q} !== {1'b0, 1'b1, (i == 3), w[i]}) begin
        n_bad++;
        $display("FAIL single_bit%0d rvlq=%b expected %b", i, {ready, valid, last, Q},
                 {1'b0, 1'b1, (i == 3), w[i]});
      end
      tick();
    end
    n_cmp++;
    if ({ready, valid, last, Q} !== 4'b1000) begin
      n_bad++;
      $display("FAIL single_idle rvlq=%b expected 1000", {ready, valid, last, Q});
    end
  endtask

  task automatic test_back_to_back();
    logic [0:8] bq;
    logic [0:8] bv;
    bq = 9'b1011_0_0001;
    bv = 9'b1111_0_1111;
    D = 4'b1011; en = 1'b1;
    tick();
    D = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if ({ready, valid, last, Q} !== {(i == 4), bv[i], (i == 3 || i == 8), bq[i]}) begin
        n_bad++;
        $display("FAIL b2b_cyc%0d rvlq=%b expected %b", i, {ready, valid, last, Q},
                 {(i == 4), bv[i], (i == 3 || i == 8), bq[i]});
      end
      tick();
      if (i == 4) en = 1'b0;
    end
    n_cmp++;
    if ({ready, valid, last, Q} !== 4'b1000) begin
      n_bad++;
      $display("FAIL b2b_idle rvlq=%b expected 1000", {ready, valid, last, Q});
    end
  endtask

  task automatic test_stall();
    D = 4'b1100; en = 1'b1;
    tick();
    en = 1'b0;
    n_cmp++;
    if ({ready, valid, last, Q} !== 4'b0101) begin
      n_bad++;
      $display("FAIL stall_b0 rvlq=%b expected 0101", {ready, valid, last, Q});
    end
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({ready, valid, last, Q} !== 4'b0101) begin
        n_bad++;
        $display("FAIL stall_hold%0d rvlq=%b expected 0101", k, {ready, valid, last, Q});
      end
      tick();
    end
    stall = 1'b0;
    n_cmp++;
    if ({ready, valid, last, Q} !== 4'b0101) begin
      n_bad++;
      $display("FAIL stall_b1 rvlq=%b expected 0101", {ready, valid, last, Q});
    end
    tick();
    n_cmp++;
    if ({ready, valid, last, Q} !== 4'b0100) begin
      n_bad++;
      $display("FAIL stall_b2 rvlq=%b expected 0100", {ready, valid, last, Q});
    end
    tick();
    stall = 1'b1;
    tick();
    n_cmp++;
    if ({ready, valid, last, Q} !== 4'b0110) begin
      n_bad++;
      $display("FAIL stall_last rvlq=%b expected 0110", {ready, valid, last, Q});
    end
    stall = 1'b0;
    tick();
    n_cmp++;
    if ({ready, valid, last, Q} !== 4'b1000) begin
      n_bad++;
      $display("FAIL stall_idle rvlq=%b expected 1000", {ready, valid, last, Q});
    end
    // stall in idle must not block acceptance
    stall = 1'b1; D = 4'b1000; en = 1'b1;
    tick();
    stall = 1'b0; en = 1'b0;
    n_cmp++;
    if ({ready, valid, last, Q} !== 4'b0101) begin
      n_bad++;
      $display("FAIL stall_idle_accept rvlq=%b expected 0101", {ready, valid, last, Q});
    end
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_ignored_load();
    logic [0:3] w;
    w = 4'b1010;
    D = w; en = 1'b1;
    tick();
    D = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({ready, valid, last, Q} !== {1'b0, 1'b1, (i == 3), w[i]}) begin
        n_bad++;
        $display("FAIL ignore_bit%0d rvlq=%b expected %b", i, {ready, valid, last, Q},
                 {1'b0, 1'b1, (i == 3), w[i]});
      end
      en = (i < 3);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({ready, valid, last, Q} !== 4'b1000) begin
        n_bad++;
        $display("FAIL ignore_idle%0d rvlq=%b expected 1000", k, {ready, valid, last, Q});
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    D = 4'b1111; en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    n_cmp++;
    if ({ready, valid, last, Q} !== 4'b0101) begin
      n_bad++;
      $display("FAIL midrst_b1 rvlq=%b expected 0101", {ready, valid, last, Q});
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({ready, valid, last, Q} !== 4'b1000) begin
        n_bad++;
        $display("FAIL midrst_idle%0d rvlq=%b expected 1000", k, {ready, valid, last, Q});
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    for (int c = 0; c < 1500; c++) begin
      rst_n  = ($urandom_range(0, 79) != 0);
      en     = ($urandom_range(0, 2) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      D      = 4'($urandom);
      en2    = ($urandom_range(0, 3) != 0);
      stall2 = ($urandom_range(0, 2) == 0);
      D2     = 5'($urandom);
      tick();
      exp_a = {(qa.size() == 0), (qa.size() != 0), (qa.size() == 1),
               (qa.size() != 0) ? qa[0] : 1'b0};
      exp_b = {(qb.size() == 0), (qb.size() != 0), (qb.size() == 1),
               (qb.size() != 0) ? qb[0] : 1'b0};
      n_cmp++;
      if ({ready, valid, last, Q} !== exp_a) begin
        n_bad++;
        $display("FAIL rand_a cyc%0d rvlq=%b expected %b", c, {ready, valid, last, Q}, exp_a);
      end
      n_cmp++;
      if ({ready2, valid2, last2, Q2} !== exp_b) begin
        n_bad++;
        $display("FAIL rand_b cyc%0d rvlq=%b expected %b", c, {ready2, valid2, last2, Q2}, exp_b);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0; en = 1'b0; stall = 1'b0; D = '0;
    en2 = 1'b0; stall2 = 1'b0; D2 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_ignored_load();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
